// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central sequencer for the 5-stage pipeline (fetch/decode/execute/memory/
// writeback). It inserts bubbles on load-use hazards, freezes the pipe while
// data memory is busy, and owns branch_ref. branch_ref is the epoch bit that
// every pipeline unit compares with its captured branch bit. A mismatch makes
// that unit emit a NOP, which squashes wrong-path instructions.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall and flush
// performance counters. When the macro is undefined, both counters read 0 and
// cnt_clr is ignored.
//
// Parameters
//   FLUSH_CYCLES       cycles FLUSH is held after a taken branch (1..15)
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (1..7)
//   CNT_W              width of the performance counters
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   dec_valid/rn/rm/uses_rn/rm    decode-stage source operand information
//   ex_valid/is_load/rd           execute-stage destination information
//   br_taken                      execute resolved a taken branch
//   mem_req, mem_ready            data-memory handshake of the memory stage
//   cnt_clr                       clear the performance counters
//   stall_if/id/ex, bubble_ex     pipeline hold and bubble controls
//   branch_ref                    epoch bit sent to all pipeline units
//   flush_active                  controller is in FLUSH
//   stall_count, flush_count      saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int unsigned FLUSH_CYCLES      = 2,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [3:0]       dec_rn,
    input  logic [3:0]       dec_rm,
    input  logic             dec_uses_rn,
    input  logic             dec_uses_rm,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [3:0]       ex_rd,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             branch_ref,
    output logic             flush_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {StRun, StLstall, StMemWait, StFlush} state_e;

    localparam logic [3:0] FlushLoad  = 4'(FLUSH_CYCLES - 1);
    // Only used when LOAD_STALL_CYCLES > 1; the first bubble is issued from StRun.
    localparam logic [3:0] LstallLoad = 4'(LOAD_STALL_CYCLES - 2);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       branch_ref_q;
    logic       hz_load, mem_wait, br_accept;

    always_comb begin
        hz_load  = ex_valid & ex_is_load & dec_valid &
                   ((dec_uses_rn & (dec_rn == ex_rd)) | (dec_uses_rm & (dec_rm == ex_rd)));
        mem_wait = mem_req & ~mem_ready;

        state_d      = state_q;
        cnt_d        = cnt_q;
        br_accept    = 1'b0;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        bubble_ex    = 1'b0;
        flush_active = 1'b0;

        unique case (state_q)
            StRun, StLstall, StFlush: begin
                flush_active = (state_q == StFlush);
                if (br_taken) begin
                    br_accept = 1'b1;
                    cnt_d     = FlushLoad;
                    state_d   = StFlush;
                end else if (mem_wait) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    state_d  = StMemWait;
                end else if ((state_q == StLstall) || ((state_q == StRun) && hz_load)) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (state_q == StRun) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            cnt_d   = LstallLoad;
                            state_d = StLstall;
                        end
                    end else if (cnt_q == 4'd0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (state_q == StFlush) begin
                    // Decode holds wrong-path work here, so hazards are not checked.
                    if (cnt_q == 4'd0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StMemWait: begin
                // Execute is frozen, so br_taken and hz_load are stale and ignored.
                stall_if = ~mem_ready;
                stall_id = ~mem_ready;
                stall_ex = ~mem_ready;
                if (mem_ready) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (rst) begin
            stall_if     = 1'b0;
            stall_id     = 1'b0;
            stall_ex     = 1'b0;
            bubble_ex    = 1'b0;
            flush_active = 1'b0;
            br_accept    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            cnt_q        <= 4'd0;
            branch_ref_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (br_accept) begin
                branch_ref_q <= ~branch_ref_q;
            end
        end
    end

    assign branch_ref = branch_ref_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_count_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (stall_if && !(&stall_count_q)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
            if (br_accept && !(&flush_count_q)) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    logic unused_perf;
    assign unused_perf = ^{cnt_clr, br_accept};
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Runs two controller instances from the same stimulus:
//   inst0: FLUSH_CYCLES=2, LOAD_STALL_CYCLES=1, CNT_W=16
//   inst1: FLUSH_CYCLES=3, LOAD_STALL_CYCLES=3, CNT_W=4 (counter saturation)
// The reference model tracks a mode and the number of bubble or flush cycles
// still owed. Every cycle it predicts all outputs of both instances.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, dec_valid, dec_uses_rn, dec_uses_rm;
    logic       ex_valid, ex_is_load, br_taken, mem_req, mem_ready, cnt_clr;
    logic [3:0] dec_rn, dec_rm, ex_rd;

    logic        a_stall_if, a_stall_id, a_stall_ex, a_bubble_ex, a_branch_ref, a_flush_active;
    logic [15:0] a_stall_count, a_flush_count;
    logic        b_stall_if, b_stall_id, b_stall_ex, b_bubble_ex, b_branch_ref, b_flush_active;
    logic [3:0]  b_stall_count, b_flush_count;

    pipeline_hazard_controller #(
        .FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm),
        .dec_uses_rn(dec_uses_rn), .dec_uses_rm(dec_uses_rm), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .br_taken(br_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr), .stall_if(a_stall_if),
        .stall_id(a_stall_id), .stall_ex(a_stall_ex), .bubble_ex(a_bubble_ex),
        .branch_ref(a_branch_ref), .flush_active(a_flush_active),
        .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    pipeline_hazard_controller #(
        .FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(3), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm),
        .dec_uses_rn(dec_uses_rn), .dec_uses_rm(dec_uses_rm), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .br_taken(br_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr), .stall_if(b_stall_if),
        .stall_id(b_stall_id), .stall_ex(b_stall_ex), .bubble_ex(b_bubble_ex),
        .branch_ref(b_branch_ref), .flush_active(b_flush_active),
        .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    localparam int MRun = 0, MLstall = 1, MMem = 2, MFlush = 3;

    int md[2]     = '{MRun, MRun};
    int left[2]   = '{0, 0};
    bit ref_m[2]  = '{1'b0, 1'b0};
    int scnt[2]   = '{0, 0};
    int fcnt[2]   = '{0, 0};
    int fc[2]     = '{2, 3};
    int lsc[2]    = '{1, 3};
    int cmax[2]   = '{65535, 15};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a negedge with the inputs for this cycle already applied.
    task automatic step();
        bit hz, mw, acc;
        bit e_if, e_id, e_ex, e_bub, e_fl;
        logic [5:0]  g;
        logic [31:0] g_sc, g_fc;
        #1;
        hz = ex_valid && ex_is_load && dec_valid &&
             ((dec_uses_rn && dec_rn == ex_rd) || (dec_uses_rm && dec_rm == ex_rd));
        mw = mem_req && !mem_ready;
        for (int k = 0; k < 2; k++) begin
            e_if = 0; e_id = 0; e_ex = 0; e_bub = 0; e_fl = 0; acc = 0;
            if (!rst) begin
                e_fl = (md[k] == MFlush);
                if (md[k] == MMem) begin
                    e_if = !mem_ready; e_id = !mem_ready; e_ex = !mem_ready;
                end else if (br_taken) begin
                    acc = 1;
                end else if (mw) begin
                    e_if = 1; e_id = 1; e_ex = 1;
                end else if (md[k] == MLstall || (md[k] == MRun && hz)) begin
                    e_if = 1; e_id = 1; e_bub = 1;
                end
            end
            if (k == 0) begin
                g = {a_stall_if, a_stall_id, a_stall_ex, a_bubble_ex, a_branch_ref, a_flush_active};
                g_sc = 32'(a_stall_count);
                g_fc = 32'(a_flush_count);
            end else begin
                g = {b_stall_if, b_stall_id, b_stall_ex, b_bubble_ex, b_branch_ref, b_flush_active};
                g_sc = 32'(b_stall_count);
                g_fc = 32'(b_flush_count);
            end
            check_val($sformatf("inst%0d stall_if", k), 32'(g[5]), 32'(e_if));
            check_val($sformatf("inst%0d stall_id", k), 32'(g[4]), 32'(e_id));
            check_val($sformatf("inst%0d stall_ex", k), 32'(g[3]), 32'(e_ex));
            check_val($sformatf("inst%0d bubble_ex", k), 32'(g[2]), 32'(e_bub));
            check_val($sformatf("inst%0d branch_ref", k), 32'(g[1]), 32'(ref_m[k]));
            check_val($sformatf("inst%0d flush_active", k), 32'(g[0]), 32'(e_fl));
            check_val($sformatf("inst%0d stall_count", k), g_sc, PerfOn ? scnt[k] : 0);
            check_val($sformatf("inst%0d flush_count", k), g_fc, PerfOn ? fcnt[k] : 0);

            // Next-state of the reference model
            if (rst) begin
                md[k] = MRun; left[k] = 0; ref_m[k] = 0; scnt[k] = 0; fcnt[k] = 0;
            end else begin
                if (cnt_clr) begin
                    scnt[k] = 0; fcnt[k] = 0;
                end else begin
                    if (e_if && scnt[k] < cmax[k]) scnt[k]++;
                    if (acc && fcnt[k] < cmax[k]) fcnt[k]++;
                end
                if (acc) begin
                    ref_m[k] = !ref_m[k]; left[k] = fc[k]; md[k] = MFlush;
                end else if (md[k] == MMem) begin
                    if (mem_ready) md[k] = MRun;
                end else if (mw) begin
                    md[k] = MMem;
                end else if (md[k] == MRun && hz) begin
                    left[k] = lsc[k] - 1;
                    md[k] = (left[k] > 0) ? MLstall : MRun;
                end else if (md[k] == MLstall || md[k] == MFlush) begin
                    left[k]--;
                    if (left[k] == 0) md[k] = MRun;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_uses_rn = 0; dec_uses_rm = 0; dec_rn = 0; dec_rm = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; br_taken = 0;
        mem_req = 0; mem_ready = 0; cnt_clr = 0;
    endtask

    task automatic set_hazard(input logic [3:0] rn);
        ex_valid = 1; ex_is_load = 1; ex_rd = 4'd3;
        dec_valid = 1; dec_rn = rn; dec_uses_rn = 1;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        // Reset held for two checked cycles
        step();
        step();
        rst = 0;
        step();
        // Load-use hazard for one cycle, then execute holds the bubble
        set_hazard(4'd3);
        step();
        idle_inputs();
        repeat (4) step();
        // Different register: no stall
        set_hazard(4'd4);
        step();
        idle_inputs();
        step();
        // Taken branch
        br_taken = 1;
        step();
        br_taken = 0;
        repeat (4) step();
        // Memory wait of four cycles with a branch pulse in the middle
        mem_req = 1; mem_ready = 0;
        step();
        br_taken = 1;
        step();
        br_taken = 0;
        repeat (2) step();
        mem_ready = 1;
        step();
        idle_inputs();
        step();
        // Branch with a concurrent hazard and memory wait, then a second branch
        set_hazard(4'd3);
        br_taken = 1; mem_req = 1; mem_ready = 0;
        step();
        idle_inputs();
        br_taken = 1;
        step();
        br_taken = 0;
        repeat (5) step();
        // Counter clear with a concurrent stall, then 20 stall cycles
        set_hazard(4'd3);
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        repeat (20) step();
        idle_inputs();
        repeat (4) step();
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 399) == 0);
            dec_valid   = 1'($urandom_range(0, 1));
            dec_uses_rn = 1'($urandom_range(0, 1));
            dec_uses_rm = 1'($urandom_range(0, 1));
            dec_rn      = 4'($urandom_range(0, 3));
            dec_rm      = 4'($urandom_range(0, 3));
            ex_valid    = 1'($urandom_range(0, 1));
            ex_is_load  = 1'($urandom_range(0, 1));
            ex_rd       = 4'($urandom_range(0, 3));
            br_taken    = ($urandom_range(0, 9) == 0);
            mem_req     = ($urandom_range(0, 3) == 0);
            mem_ready   = ($urandom_range(0, 2) != 0);
            cnt_clr     = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0;
        idle_inputs();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
